// File: rtl/odd_even_pkg.sv
// Shared types and constants for the odd/even stream generator.
package odd_even_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [3:0] ODD_SEED   = 4'b1001;
  localparam logic [3:0] EVEN_SEED  = 4'b0110;
  // x^4 + x^3 + 1, maximal length for a 4-bit Fibonacci LFSR
  localparam logic [3:0] LFSR_TAPS  = 4'b1100;
endpackage

// File: rtl/odd_even_value_gen.sv
// Per-parity value source: reloads on init, advances on step.
// ODD_EVEN_GEN_LFSR_EN selects an LFSR source instead of an incrementing one.
module odd_even_value_gen
  import odd_even_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter bit PARITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  output logic [DATA_W-1:0] word
);
`ifdef ODD_EVEN_GEN_LFSR_EN
  localparam logic [DATA_W-1:0] SEED = PARITY ? DATA_W'(ODD_SEED) : DATA_W'(EVEN_SEED);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);
  logic [DATA_W-1:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr <= SEED;
    else if (init) lfsr <= SEED;
    else if (step) lfsr <= {lfsr[DATA_W-2:0], ^(lfsr & TAPS)};
  end

  // LSB is overridden so the word always carries the requested parity
  assign word = {lfsr[DATA_W-1:1], PARITY};
`else
  localparam logic [DATA_W-1:0] FIRST = DATA_W'(PARITY);
  logic [DATA_W-1:0] val;

  // stepping by 2 wraps naturally: max odd -> 1, max even -> 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       val <= FIRST;
    else if (init) val <= FIRST;
    else if (step) val <= val + DATA_W'(2);
  end

  assign word = val;
`endif
endmodule

// File: rtl/odd_even_stream_gen.sv
// Emits a programmed count of odd and even words on a valid/ready stream, alternating parity.
// ODD_EVEN_GEN_LFSR_EN switches the value sources to LFSRs (see odd_even_value_gen).
module odd_even_stream_gen
  import odd_even_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_odd,
  input  logic [CNT_W-1:0]  n_even,
  input  logic              ready,
  output logic [DATA_W-1:0] d_out,
  output logic              valid,
  output logic              last,
  output logic              busy,
  output logic              done
);
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  rem_odd, rem_even, rem_odd_nxt, rem_even_nxt;
  logic              par, par_nxt;   // 1: current word is odd
  logic [CNT_W:0]    rem_sum;
  logic              accept, xfer;
  logic [DATA_W-1:0] odd_word, even_word;

  assign accept  = start && (state == IDLE);
  assign valid   = (state == SEND);
  assign busy    = valid;
  assign done    = (state == DONE);
  assign xfer    = valid && ready;
  assign rem_sum = {1'b0, rem_odd} + {1'b0, rem_even};
  assign last    = valid && (rem_sum == (CNT_W+1)'(1));
  assign d_out   = valid ? (par ? odd_word : even_word) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem_odd  <= '0;
      rem_even <= '0;
      par      <= 1'b1;
    end else begin
      state    <= state_nxt;
      rem_odd  <= rem_odd_nxt;
      rem_even <= rem_even_nxt;
      par      <= par_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_odd_nxt  = rem_odd;
    rem_even_nxt = rem_even;
    par_nxt      = par;
    case (state)
      IDLE: if (start) begin
        rem_odd_nxt  = n_odd;
        rem_even_nxt = n_even;
        par_nxt      = (n_odd != '0);
        state_nxt    = (n_odd != '0 || n_even != '0) ? SEND : DONE;
      end
      SEND: if (ready) begin
        // switch parity only if the other one still has words left
        if (par) begin
          rem_odd_nxt = rem_odd - CNT_W'(1);
          par_nxt     = (rem_even == '0);
        end else begin
          rem_even_nxt = rem_even - CNT_W'(1);
          par_nxt      = (rem_odd != '0);
        end
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  odd_even_value_gen #(.DATA_W(DATA_W), .PARITY(1'b1)) u_odd (
    .clk(clk), .rst(rst), .init(accept), .step(xfer && par), .word(odd_word)
  );

  odd_even_value_gen #(.DATA_W(DATA_W), .PARITY(1'b0)) u_even (
    .clk(clk), .rst(rst), .init(accept), .step(xfer && !par), .word(even_word)
  );
endmodule

// File: tb/tb_odd_even_stream_gen.sv
// Scoreboard bench for odd_even_stream_gen: stimulus queues expected words, monitor pops on transfers.
module tb_odd_even_stream_gen;
  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic [3:0] n_odd, n_even;
  logic [3:0] d_out;
  logic       valid, last, busy, done;

  typedef struct {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  odd_even_stream_gen #(.DATA_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .n_odd(n_odd), .n_even(n_even),
    .ready(ready), .d_out(d_out), .valid(valid), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  // accepted at the second posedge; returns just after it
  task automatic start_run(input logic [3:0] no, input logic [3:0] ne);
    @(posedge clk); #1;
    start = 1'b1; n_odd = no; n_even = ne;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_valid_at_done"}, valid, 0);
    check({name, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({name, "_done_1cyc"}, done, 0);
    check({name, "_queue_empty"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (q.size() == 0) begin
        check("unexpected_word", d_out, -1);
      end else begin
        exp_t e;
        e = q.pop_front();
`ifdef ODD_EVEN_GEN_LFSR_EN
        check("word_parity", d_out[0], e.data[0]);
`else
        check("word_data", d_out, e.data);
`endif
        check("word_last", last, e.last);
      end
    end
  end

  initial begin
    logic [3:0] held;
    rst = 1'b1; start = 1'b0; ready = 1'b1; n_odd = '0; n_even = '0;
    #12;
    check("rst_d_out", d_out, 0);
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // 1: 2 odd + 2 even, back-to-back
    push(4'd1, 0); push(4'd0, 0); push(4'd3, 0); push(4'd2, 1);
    start_run(4'd2, 4'd2);
    @(negedge clk);
    check("t1_busy", busy, 1);
    wait_done("t1");

    // 2: stall on the first word, then 1,0,3,5
    ready = 1'b0;
    push(4'd1, 0); push(4'd0, 0); push(4'd3, 0); push(4'd5, 1);
    start_run(4'd3, 4'd1);
    @(negedge clk);
    held = d_out;
    check("t2_stall_valid", valid, 1);
    repeat (3) begin
      @(negedge clk);
      check("t2_stall_valid", valid, 1);
      check("t2_stall_stable", d_out, held);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_done("t2");

    // 3: odd-only run wraps 15 -> 1
    for (int i = 0; i < 9; i++) push(4'((2*i+1) % 16), i == 8);
    start_run(4'd9, 4'd0);
    wait_done("t3");

    // 4: empty run
    start_run(4'd0, 4'd0);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_valid", valid, 0);
    @(negedge clk);
    check("t4_done_off", done, 0);
    check("t4_valid_off", valid, 0);

    // 5: reset after two transfers abandons the run
    push(4'd1, 0); push(4'd0, 0);
    start_run(4'd3, 4'd3);
    @(posedge clk); @(posedge clk); #1;
    check("t5_popped", q.size(), 0);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", valid, 0);
    check("t5_rst_d_out", d_out, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_last", last, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push(4'd1, 1);
    start_run(4'd1, 4'd0);
    @(negedge clk);
    check("t5_single_last", last, 1);
    wait_done("t5");

    // 6: start while busy is ignored
    push(4'd1, 0); push(4'd0, 0); push(4'd3, 0); push(4'd2, 1);
    start_run(4'd2, 4'd2);
    start = 1'b1; n_odd = 4'd5; n_even = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6");

    repeat (3) @(negedge clk);
    check("idle_valid", valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
